// File: rtl/gc_stream_pkg.sv
// -----------------------------------------------------------------------------
// gc_stream_pkg
// Shared types for the garbled-circuit stream sequencer: output word classes,
// garbler tag encodings, sequencer FSM states and the default-width entry
// record. Modules with non-default S/K declare a record with the same field
// order locally, so a packed entry always reads {kind, cid, index, data}.
// -----------------------------------------------------------------------------
package gc_stream_pkg;

  // Word class carried on out_kind.
  typedef enum logic [1:0] {
    LABEL = 2'd0,
    KEY   = 2'd1,
    TABLE = 2'd2,
    MASK  = 2'd3
  } gc_kind_t;

  // Tag encodings when tag[2] is clear (tag[2] set always means label words).
  localparam logic [2:0] TAG_KEY   = 3'b001;
  localparam logic [2:0] TAG_TABLE = 3'b010;
  localparam logic [2:0] TAG_MASK  = 3'b011;

  // Sequencer control states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } gc_state_t;

  // Default garbler widths.
  localparam int unsigned GC_S = 16;
  localparam int unsigned GC_K = 128;

  // One buffered output word at the default widths.
  typedef struct packed {
    gc_kind_t          kind;
    logic [GC_S-1:0]   cid;
    logic [GC_S-1:0]   index;
    logic [GC_K-1:0]   data;
  } gc_entry_t;

endpackage

// File: rtl/gc_stream_sequencer_fifo.sv
// -----------------------------------------------------------------------------
// gc_fifo_2w1r
// Dual-push / single-pop FIFO with a registered head. Up to two entries are
// written per cycle (wdata0 first, then wdata1); the head entry is held in an
// output register so a word pushed into an empty FIFO is visible the next
// cycle. count includes the word sitting in the head register.
// The caller guarantees that count + push_n never exceeds the depth.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (flushes the FIFO)
//   push_n_i        number of entries to write this cycle (0..2)
//   wdata0_i/1_i    entries to write, wdata0_i is the older one
//   pop_ready_i     consumer accepts the head this cycle
//   head_valid_o    head register holds a valid entry
//   head_o          head entry
//   count_o         occupancy, AW+1 bits (full distinguishable from empty)
// -----------------------------------------------------------------------------
module gc_fifo_2w1r #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    push_n_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  input  logic          pop_ready_i,
  output logic          head_valid_o,
  output logic [DW-1:0] head_o,
  output logic [AW:0]   count_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1_s;
  logic [AW:0]   count_q, count_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] head_q, head_d;
  logic          pop_s;

  // Pointer/occupancy update and selection of the entry that becomes head.
  always_comb begin
    pop_s       = valid_q && pop_ready_i;
    wr_ptr_p1_s = wr_ptr_q + AW'(1'b1);
    wr_ptr_d    = wr_ptr_q + AW'(push_n_i);
    rd_ptr_d    = rd_ptr_q + AW'(pop_s);
    count_d     = count_q + (AW+1)'(push_n_i) - (AW+1)'(pop_s);
    valid_d     = (count_d != {(AW+1){1'b0}});
    head_d      = mem_q[rd_ptr_d];
    // A word written this cycle may land exactly at the new head slot; the
    // memory has not been updated yet, so forward it straight from the input.
    if ((push_n_i != 2'd0) && (rd_ptr_d == wr_ptr_q)) begin
      head_d = wdata0_i;
    end else if ((push_n_i == 2'd2) && (rd_ptr_d == wr_ptr_p1_s)) begin
      head_d = wdata1_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array write ports (no reset needed: pointers define validity).
  always_ff @(posedge clk) begin
    if (push_n_i != 2'd0) begin
      mem_q[wr_ptr_q] <= wdata0_i;
    end
    if (push_n_i == 2'd2) begin
      mem_q[wr_ptr_p1_s] <= wdata1_i;
    end
  end

  // Pointer, occupancy and head register state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      valid_q  <= 1'b0;
      head_q   <= {DW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      // Head keeps its last value when the FIFO empties.
      head_q   <= valid_d ? head_d : head_q;
    end
  end

  assign head_valid_o = valid_q;
  assign head_o       = head_q;
  assign count_o      = count_q;

endmodule

// File: rtl/gc_stream_sequencer.sv
// -----------------------------------------------------------------------------
// gc_stream_sequencer
// Controller between the host and the garbler. Pulses gc_start, decodes the
// tagged dual-word garbler stream while running, admits each cycle's words
// all-or-nothing into a 2-write/1-read FIFO, and serialises them onto one
// valid/ready word channel. Completion is flagged once cid == CC has been
// seen and the FIFO (including its output register) has drained.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   go                         host start request (sampled in IDLE/DONE)
//   gc_start                   one-cycle garbler start pulse
//   tag, cid, index0/1, data0/1  garbler output stream
//   out_valid/out_ready        host word handshake
//   out_kind/cid/index/data    word fields (kind: 0 label,1 key,2 table,3 mask)
//   busy                       in START, RUN or DRAIN
//   done                       in DONE
//   overflow                   sticky: a capture cycle was dropped
// -----------------------------------------------------------------------------
module gc_stream_sequencer
  import gc_stream_pkg::*;
#(
  parameter int unsigned S  = 16,
  parameter int unsigned K  = 128,
  parameter int unsigned CC = 1,
  parameter int unsigned AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  output logic         gc_start,
  input  logic [2:0]   tag,
  input  logic [S-1:0] cid,
  input  logic [S-1:0] index0,
  input  logic [S-1:0] index1,
  input  logic [K-1:0] data0,
  input  logic [K-1:0] data1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_kind,
  output logic [S-1:0] out_cid,
  output logic [S-1:0] out_index,
  output logic [K-1:0] out_data,
  output logic         busy,
  output logic         done,
  output logic         overflow
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned EW    = 2 + 2*S + K;

  typedef struct packed {
    gc_kind_t     kind;
    logic [S-1:0] cid;
    logic [S-1:0] index;
    logic [K-1:0] data;
  } entry_t;

  gc_state_t   state_q, state_d;
  logic        overflow_q, overflow_d;
  entry_t      word0_s, word1_s, head_e_s;
  logic [1:0]  n_s, push_n_s;
  logic [AW:0] count_s;
  logic        end_s, capture_s, admit_s, drop_s, go_ok_s;
  logic        pop_s, drain_empty_s, head_valid_s;
  logic [EW-1:0] head_s;

  // Tag decode: word0_s is always the entry that must be queued first.
  always_comb begin
    word0_s = '0;
    word1_s = '0;
    n_s     = 2'd0;
    if (tag[2]) begin
      case (tag[1:0])
        2'b11: begin
          word0_s = '{LABEL, cid, index0, data0};
          word1_s = '{LABEL, cid, index1, data1};
          n_s     = 2'd2;
        end
        2'b01: begin
          word0_s = '{LABEL, cid, index0, data0};
          n_s     = 2'd1;
        end
        2'b10: begin
          // Only the second label is present; it still goes first in line.
          word0_s = '{LABEL, cid, index1, data1};
          n_s     = 2'd1;
        end
        default: n_s = 2'd0;
      endcase
    end else begin
      case (tag)
        TAG_KEY: begin
          word0_s = '{KEY, cid, S'(1'b0), data0};
          word1_s = '{KEY, cid, S'(1'b1), data1};
          n_s     = 2'd2;
        end
        TAG_TABLE: begin
          word0_s = '{TABLE, cid, index0, data0};
          word1_s = '{TABLE, cid, index1, data1};
          n_s     = 2'd2;
        end
        TAG_MASK: begin
          word0_s = '{MASK, cid, S'(1'b0), data0};
          n_s     = 2'd1;
        end
        default: n_s = 2'd0;
      endcase
    end
  end

  // Admission: room is judged on start-of-cycle occupancy, so a same-cycle
  // pop never makes space for this cycle's words.
  always_comb begin
    end_s         = (cid == S'(CC));
    capture_s     = (state_q == ST_RUN) && !end_s;
    admit_s       = (({1'b0, count_s} + (AW+2)'(n_s)) <= (AW+2)'(DEPTH));
    drop_s        = capture_s && (n_s != 2'd0) && !admit_s;
    push_n_s      = (capture_s && admit_s) ? n_s : 2'd0;
    go_ok_s       = go && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    pop_s         = head_valid_s && out_ready;
    // Empty after this cycle: lets done rise the cycle after the last pop.
    drain_empty_s = (count_s == {(AW+1){1'b0}}) ||
                    ((count_s == (AW+1)'(1'b1)) && pop_s);
  end

  // FSM next state and sticky overflow.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = go_ok_s ? ST_START : ST_IDLE;
      ST_START: state_d = ST_RUN;
      ST_RUN:   state_d = end_s ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_d = drain_empty_s ? ST_DONE : ST_DRAIN;
      ST_DONE:  state_d = go_ok_s ? ST_START : ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (go_ok_s) begin
      overflow_d = 1'b0;
    end else if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FSM state and overflow registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  gc_fifo_2w1r #(
    .DW (EW),
    .AW (AW)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_n_i     (push_n_s),
    .wdata0_i     (word0_s),
    .wdata1_i     (word1_s),
    .pop_ready_i  (out_ready),
    .head_valid_o (head_valid_s),
    .head_o       (head_s),
    .count_o      (count_s)
  );

  assign head_e_s  = entry_t'(head_s);
  assign out_valid = head_valid_s;
  assign out_kind  = head_e_s.kind;
  assign out_cid   = head_e_s.cid;
  assign out_index = head_e_s.index;
  assign out_data  = head_e_s.data;

  assign gc_start  = (state_q == ST_START);
  assign busy      = (state_q == ST_START) || (state_q == ST_RUN) ||
                     (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_gc_stream_sequencer.sv
module tb_gc_stream_sequencer;

  typedef struct packed {
    logic [1:0]   kind;
    logic [15:0]  cid;
    logic [15:0]  idx;
    logic [127:0] data;
  } word_t;

  typedef struct {
    logic [2:0]   tag;
    logic [15:0]  cid;
    logic [15:0]  i0;
    logic [15:0]  i1;
    logic [127:0] d0;
    logic [127:0] d1;
    int           n;
    word_t        w0;
    word_t        w1;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n, go, gc_start;
  logic [2:0]   tag;
  logic [15:0]  cid, index0, index1;
  logic [127:0] data0, data1;
  logic         out_valid, out_ready;
  logic [1:0]   out_kind;
  logic [15:0]  out_cid, out_index;
  logic [127:0] out_data;
  logic         busy, done, overflow;

  int    n_tests = 0;
  int    n_fail  = 0;
  word_t exp_q[$];
  vec_t  vecs[8];
  logic [127:0] pat_a, pat_b;

  gc_stream_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .gc_start  (gc_start),
    .tag       (tag),
    .cid       (cid),
    .index0    (index0),
    .index1    (index1),
    .data0     (data0),
    .data1     (data1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_cid   (out_cid),
    .out_index (out_index),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic word_t mkw(logic [1:0] k, logic [15:0] c, logic [15:0] ix, logic [127:0] d);
    return {k, c, ix, d};
  endfunction

  function automatic vec_t mkv(logic [2:0] t, logic [15:0] c, logic [15:0] i0, logic [15:0] i1,
                               logic [127:0] d0, logic [127:0] d1, int n, word_t w0, word_t w1);
    vec_t v;
    v.tag = t; v.cid = c; v.i0 = i0; v.i1 = i1; v.d0 = d0; v.d1 = d1;
    v.n = n; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  // Scoreboard: every accepted word is compared against the expected queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_word: got %0h, expected no word", {out_kind, out_cid, out_index, out_data});
      end else begin
        chk("word", {out_kind, out_cid, out_index, out_data}, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tagname);
    chk({tagname, "_gc_start"},  gc_start,  1'b0);
    chk({tagname, "_out_valid"}, out_valid, 1'b0);
    chk({tagname, "_out_kind"},  out_kind,  2'd0);
    chk({tagname, "_out_cid"},   out_cid,   16'd0);
    chk({tagname, "_out_index"}, out_index, 16'd0);
    chk({tagname, "_out_data"},  out_data,  128'd0);
    chk({tagname, "_busy"},      busy,      1'b0);
    chk({tagname, "_done"},      done,      1'b0);
    chk({tagname, "_overflow"},  overflow,  1'b0);
    chk({tagname, "_count"},     dut.count_s, 5'd0);
  endtask

  // go in IDLE/DONE: START next cycle, RUN the one after.
  task automatic do_go();
    go = 1'b1;
    step();
    go = 1'b0;
    chk("gc_start_pulse", gc_start, 1'b1);
    chk("busy_in_start", busy, 1'b1);
    chk("done_low_in_start", done, 1'b0);
    chk("overflow_cleared_by_go", overflow, 1'b0);
    step();
    chk("gc_start_one_cycle", gc_start, 1'b0);
  endtask

  task automatic drive(input logic [2:0] t, input logic [15:0] c, input logic [15:0] i0,
                       input logic [15:0] i1, input logic [127:0] d0, input logic [127:0] d1);
    tag = t; cid = c; index0 = i0; index1 = i1; data0 = d0; data1 = d1;
  endtask

  // Present cid == CC, then wait for the drain to complete.
  task automatic finish_run();
    drive(3'b000, 16'd1, 16'd0, 16'd0, 128'd0, 128'd0);
    step();
    cid = 16'd0;
    for (int i = 0; i < 100 && out_valid; i++) step();
    chk("drained_valid_low", out_valid, 1'b0);
    chk("done_after_last_pop", done, 1'b1);
    chk("busy_low_in_done", busy, 1'b0);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_table();
    do_go();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].tag, vecs[i].cid, vecs[i].i0, vecs[i].i1, vecs[i].d0, vecs[i].d1);
      if (vecs[i].n > 0) exp_q.push_back(vecs[i].w0);
      if (vecs[i].n > 1) exp_q.push_back(vecs[i].w1);
      step();
      if (i == 0) begin
        chk("first_word_latency", out_valid, 1'b1);
        chk("first_word_kind_index", {out_kind, out_index}, {2'd0, 16'd0});
      end
    end
    finish_run();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pat_a = {32{4'hA}};
    pat_b = {32{4'hB}};
    vecs[0] = mkv(3'b111, 16'd0, 16'd0, 16'd1, pat_a, pat_b, 2,
                  mkw(2'd0, 16'd0, 16'd0, pat_a), mkw(2'd0, 16'd0, 16'd1, pat_b));
    vecs[1] = mkv(3'b000, 16'd0, 16'd3, 16'd4, 128'h1, 128'h2, 0, '0, '0);
    vecs[2] = mkv(3'b001, 16'd2, 16'd7, 16'd9, 128'h11, 128'h22, 2,
                  mkw(2'd1, 16'd2, 16'd0, 128'h11), mkw(2'd1, 16'd2, 16'd1, 128'h22));
    vecs[3] = mkv(3'b100, 16'd2, 16'd5, 16'd6, 128'h3, 128'h4, 0, '0, '0);
    vecs[4] = mkv(3'b010, 16'd3, 16'd4, 16'd5, 128'h33, 128'h44, 2,
                  mkw(2'd2, 16'd3, 16'd4, 128'h33), mkw(2'd2, 16'd3, 16'd5, 128'h44));
    vecs[5] = mkv(3'b011, 16'd3, 16'd8, 16'd9, 128'h5, 128'h66, 1,
                  mkw(2'd3, 16'd3, 16'd0, 128'h5), '0);
    vecs[6] = mkv(3'b101, 16'd4, 16'd12, 16'd13, 128'h77, 128'h88, 1,
                  mkw(2'd0, 16'd4, 16'd12, 128'h77), '0);
    vecs[7] = mkv(3'b110, 16'd4, 16'd14, 16'd15, 128'h99, 128'hAA, 1,
                  mkw(2'd0, 16'd4, 16'd15, 128'hAA), '0);

    rst_n = 1'b0; go = 1'b0; out_ready = 1'b0;
    drive(3'b000, 16'd0, 16'd0, 16'd0, 128'd0, 128'd0);
    step();
    step();
    chk_reset_values("reset");
    rst_n = 1'b1;
    step();
    chk("idle_without_go", busy, 1'b0);

    // Run 1: decode table from IDLE.
    run_table();

    // Run 2: backpressure, full FIFO, drop with simultaneous pop.
    do_go();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(3'b010, 16'd5, 16'(2*i), 16'(2*i+1), 128'(2*i), 128'(2*i+1));
      exp_q.push_back(mkw(2'd2, 16'd5, 16'(2*i), 128'(2*i)));
      exp_q.push_back(mkw(2'd2, 16'd5, 16'(2*i+1), 128'(2*i+1)));
      step();
    end
    chk("full_count", dut.count_s, 5'd16);
    chk("full_no_overflow", overflow, 1'b0);
    chk("held_valid", out_valid, 1'b1);
    chk("held_index", out_index, 16'd0);
    drive(3'b010, 16'd5, 16'd16, 16'd17, 128'd16, 128'd17);
    step();
    chk("ninth_dropped_overflow", overflow, 1'b1);
    chk("ninth_dropped_count", dut.count_s, 5'd16);
    drive(3'b000, 16'd5, 16'd0, 16'd0, 128'd0, 128'd0);
    out_ready = 1'b1;
    step();
    chk("pop_to_15", dut.count_s, 5'd15);
    drive(3'b010, 16'd5, 16'd18, 16'd19, 128'd18, 128'd19);
    step();
    chk("at15_push2_pop1_dropped", dut.count_s, 5'd14);
    drive(3'b010, 16'd5, 16'd20, 16'd21, 128'd20, 128'd21);
    exp_q.push_back(mkw(2'd2, 16'd5, 16'd20, 128'd20));
    exp_q.push_back(mkw(2'd2, 16'd5, 16'd21, 128'd21));
    step();
    chk("at14_push2_pop1", dut.count_s, 5'd15);
    chk("overflow_sticky", overflow, 1'b1);
    finish_run();
    chk("overflow_in_done", overflow, 1'b1);

    // Run 3: restart from DONE with overflow set; same sequence as run 1.
    run_table();

    // Reset in the middle of RUN with three words queued.
    do_go();
    out_ready = 1'b0;
    drive(3'b111, 16'd0, 16'd0, 16'd1, pat_a, pat_b);
    step();
    drive(3'b011, 16'd0, 16'd0, 16'd0, 128'h5, 128'h0);
    step();
    chk("queued_three", dut.count_s, 5'd3);
    drive(3'b111, 16'd0, 16'd0, 16'd1, pat_a, pat_b);
    rst_n = 1'b0;
    step();
    chk_reset_values("midrun_reset");
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_reset_valid", out_valid, 1'b0);
      chk("post_reset_idle", busy, 1'b0);
      chk("post_reset_count", dut.count_s, 5'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
